// File: rtl/uart_time_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_time_rx
//  Purpose  : 8N1 UART receiver that decodes "Thhmmss\r" / "Ahhmm\r" commands
//             into BCD time/alarm digits with a one-cycle load strobe.
//  Revision : 1.0  initial release
// ============================================================================
module uart_time_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic       set_vld,
  output logic       set_alarm,
  output logic [3:0] hour_h,
  output logic [3:0] hour_l,
  output logic [3:0] min_h,
  output logic [3:0] min_l,
  output logic [3:0] sec_h,
  output logic [3:0] sec_l,
  output logic       cmd_err
);

  localparam int c_bit_cnt = CLK_FREQ / BAUD;
  localparam int c_cnt_w   = $clog2(c_bit_cnt + 1);
  localparam logic [c_cnt_w-1:0] c_full_last = c_cnt_w'(c_bit_cnt - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_bit_cnt / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_DIGIT, P_END} p_state_t;

  rx_state_t          r_rx_state, w_rx_next;
  p_state_t           r_p_state, w_p_next;
  logic               r_rxd_m, r_rxd_s, r_rxd_d;
  logic [c_cnt_w-1:0] r_bit_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               w_fall, w_half_hit, w_full_hit;
  logic               w_byte_vld, w_frame_err;

  // index 0 = hour_h ... index 5 = sec_l
  logic [5:0][3:0]    r_shadow, r_digits;
  logic [2:0]         r_dig_idx, r_n_digits;
  logic               r_is_alarm, r_set_vld, r_set_alarm, r_cmd_err;
  logic               w_is_t, w_is_a, w_is_cr, w_is_digit, w_range_ok;
  logic               w_load, w_cmd_err;

  // ---------------- synchroniser, reset to idle-high to avoid a false edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_m <= 1'b1;
      r_rxd_s <= 1'b1;
      r_rxd_d <= 1'b1;
    end else begin
      r_rxd_m <= uart_rxd;
      r_rxd_s <= r_rxd_m;
      r_rxd_d <= r_rxd_s;
    end
  end

  assign w_fall     = r_rxd_d & ~r_rxd_s;
  assign w_half_hit = (r_bit_cnt == c_half_last);
  assign w_full_hit = (r_bit_cnt == c_full_last);

  // ---------------- bit-level FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_state <= R_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next   = r_rx_state;
    w_byte_vld  = 1'b0;
    w_frame_err = 1'b0;
    case (r_rx_state)
      R_IDLE:  if (w_fall) w_rx_next = R_START;
      R_START: if (w_half_hit) w_rx_next = r_rxd_s ? R_IDLE : R_DATA;
      R_DATA:  if (w_full_hit && (r_bit_idx == 3'd7)) w_rx_next = R_STOP;
      R_STOP: begin
        if (w_full_hit) begin
          w_rx_next   = R_IDLE;
          w_byte_vld  = r_rxd_s;
          w_frame_err = ~r_rxd_s;
        end
      end
      default: w_rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_rx_state)
        R_START: r_bit_cnt <= w_half_hit ? '0 : r_bit_cnt + c_cnt_one;
        R_DATA: begin
          if (w_full_hit) begin
            r_bit_cnt <= '0;
            r_bit_idx <= r_bit_idx + 3'd1;
            r_shift   <= {r_rxd_s, r_shift[7:1]};
          end else begin
            r_bit_cnt <= r_bit_cnt + c_cnt_one;
          end
        end
        R_STOP:  r_bit_cnt <= w_full_hit ? '0 : r_bit_cnt + c_cnt_one;
        default: begin
          r_bit_cnt <= '0;
          r_bit_idx <= '0;
        end
      endcase
    end
  end

  // ---------------- command parser
  assign w_is_t     = (r_shift == 8'h54);
  assign w_is_a     = (r_shift == 8'h41);
  assign w_is_cr    = (r_shift == 8'h0D);
  assign w_is_digit = (r_shift >= 8'h30) && (r_shift <= 8'h39);

  assign w_range_ok = (r_shadow[0] <= 4'd2)
                   && !((r_shadow[0] == 4'd2) && (r_shadow[1] > 4'd3))
                   && (r_shadow[2] <= 4'd5)
                   && (r_is_alarm || (r_shadow[4] <= 4'd5));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_p_state <= P_IDLE;
    else        r_p_state <= w_p_next;
  end

  always_comb begin
    w_p_next  = r_p_state;
    w_load    = 1'b0;
    w_cmd_err = 1'b0;
    if (w_frame_err) begin
      w_p_next  = P_IDLE;
      w_cmd_err = 1'b1;
    end else if (w_byte_vld) begin
      case (r_p_state)
        P_IDLE: if (w_is_t || w_is_a) w_p_next = P_DIGIT;
        P_DIGIT: begin
          if (w_is_t || w_is_a) begin
            w_p_next = P_DIGIT;
          end else if (w_is_digit) begin
            if (r_dig_idx == r_n_digits - 3'd1) w_p_next = P_END;
          end else begin
            w_p_next  = P_IDLE;
            w_cmd_err = 1'b1;
          end
        end
        P_END: begin
          w_p_next  = P_IDLE;
          w_load    = w_is_cr & w_range_ok;
          w_cmd_err = ~(w_is_cr & w_range_ok);
        end
        default: w_p_next = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow    <= '0;
      r_dig_idx   <= '0;
      r_n_digits  <= '0;
      r_is_alarm  <= 1'b0;
      r_digits    <= '0;
      r_set_alarm <= 1'b0;
      r_set_vld   <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_set_vld <= w_load;
      r_cmd_err <= w_cmd_err;
      if (w_byte_vld && (w_is_t || w_is_a) && (r_p_state != P_END)) begin
        r_shadow   <= '0;
        r_dig_idx  <= '0;
        r_n_digits <= w_is_a ? 3'd4 : 3'd6;
        r_is_alarm <= w_is_a;
      end else if (w_byte_vld && (r_p_state == P_DIGIT) && w_is_digit) begin
        r_shadow[r_dig_idx] <= r_shift[3:0];
        r_dig_idx           <= r_dig_idx + 3'd1;
      end
      if (w_load) begin
        r_digits    <= r_shadow;
        r_set_alarm <= r_is_alarm;
        if (r_is_alarm) begin
          r_digits[4] <= 4'd0;
          r_digits[5] <= 4'd0;
        end
      end
    end
  end

  assign set_vld   = r_set_vld;
  assign set_alarm = r_set_alarm;
  assign cmd_err   = r_cmd_err;
  assign hour_h    = r_digits[0];
  assign hour_l    = r_digits[1];
  assign min_h     = r_digits[2];
  assign min_l     = r_digits[3];
  assign sec_h     = r_digits[4];
  assign sec_l     = r_digits[5];

endmodule
`default_nettype wire

// File: tb/tb_uart_time_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_time_rx
//  Purpose  : Directed self-checking bench for uart_time_rx (64 clk per bit).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_time_rx;

  localparam int c_clk_freq = 6_400_000;
  localparam int c_baud     = 100_000;
  localparam int c_bit      = c_clk_freq / c_baud;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       set_vld, set_alarm, cmd_err;
  logic [3:0] hour_h, hour_l, min_h, min_l, sec_h, sec_l;
  logic [23:0] digits;

  int n_checks = 0;
  int n_pass   = 0;
  int vld_cnt  = 0;
  int err_cnt  = 0;

  uart_time_rx #(.CLK_FREQ(c_clk_freq), .BAUD(c_baud)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd),
    .set_vld(set_vld), .set_alarm(set_alarm),
    .hour_h(hour_h), .hour_l(hour_l), .min_h(min_h), .min_l(min_l),
    .sec_h(sec_h), .sec_l(sec_l), .cmd_err(cmd_err)
  );

  assign digits = {hour_h, hour_l, min_h, min_l, sec_h, sec_l};

  always #5 clk = ~clk;

  // pulse counters: a stuck-high strobe counts more than once
  always @(negedge clk) begin
    if (set_vld) vld_cnt++;
    if (cmd_err) err_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (c_bit) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (c_bit) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (c_bit) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({set_vld, set_alarm, cmd_err} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {set_vld, set_alarm, cmd_err});
    else n_pass++;
    n_checks++;
    if (digits !== 24'h000000) $display("FAIL reset_digits: got %h want 000000", digits);
    else n_pass++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_time_load;
    int v0, e0;
    v0 = vld_cnt; e0 = err_cnt;
    send_str("T123456\r");
    n_checks++;
    if (vld_cnt - v0 !== 1) $display("FAIL time_vld: got %0d want 1", vld_cnt - v0); else n_pass++;
    n_checks++;
    if (err_cnt - e0 !== 0) $display("FAIL time_err: got %0d want 0", err_cnt - e0); else n_pass++;
    n_checks++;
    if (set_alarm !== 1'b0) $display("FAIL time_alarm: got %b want 0", set_alarm); else n_pass++;
    n_checks++;
    if (digits !== 24'h123456) $display("FAIL time_digits: got %h want 123456", digits); else n_pass++;
  endtask

  task automatic test_alarm_load;
    int v0, e0;
    v0 = vld_cnt; e0 = err_cnt;
    send_str("A0730\r");
    n_checks++;
    if (vld_cnt - v0 !== 1) $display("FAIL alarm_vld: got %0d want 1", vld_cnt - v0); else n_pass++;
    n_checks++;
    if (err_cnt - e0 !== 0) $display("FAIL alarm_err: got %0d want 0", err_cnt - e0); else n_pass++;
    n_checks++;
    if (set_alarm !== 1'b1) $display("FAIL alarm_flag: got %b want 1", set_alarm); else n_pass++;
    n_checks++;
    if (digits !== 24'h073000) $display("FAIL alarm_digits: got %h want 073000", digits); else n_pass++;
  endtask

  task automatic test_range_errors;
    string bad [2] = '{"T245959\r", "T126059\r"};
    int v0, e0;
    for (int k = 0; k < 2; k++) begin
      v0 = vld_cnt; e0 = err_cnt;
      send_str(bad[k]);
      n_checks++;
      if (err_cnt - e0 !== 1) $display("FAIL range%0d_err: got %0d want 1", k, err_cnt - e0); else n_pass++;
      n_checks++;
      if (vld_cnt - v0 !== 0) $display("FAIL range%0d_vld: got %0d want 0", k, vld_cnt - v0); else n_pass++;
      n_checks++;
      if ({set_alarm, digits} !== {1'b1, 24'h073000})
        $display("FAIL range%0d_hold: got %b/%h want 1/073000", k, set_alarm, digits);
      else n_pass++;
    end
  endtask

  task automatic test_framing;
    int v0, e0;
    v0 = vld_cnt; e0 = err_cnt;
    send_byte(8'h54, 1'b1);
    send_byte(8'h31, 1'b1);
    send_byte(8'h32, 1'b0);
    repeat (2 * c_bit) @(negedge clk);
    n_checks++;
    if (err_cnt - e0 !== 1) $display("FAIL frame_err: got %0d want 1", err_cnt - e0); else n_pass++;
    n_checks++;
    if (vld_cnt - v0 !== 0) $display("FAIL frame_vld: got %0d want 0", vld_cnt - v0); else n_pass++;
    v0 = vld_cnt; e0 = err_cnt;
    send_str("T000000\r");
    n_checks++;
    if (vld_cnt - v0 !== 1) $display("FAIL zero_vld: got %0d want 1", vld_cnt - v0); else n_pass++;
    n_checks++;
    if (err_cnt - e0 !== 0) $display("FAIL zero_err: got %0d want 0", err_cnt - e0); else n_pass++;
    n_checks++;
    if ({set_alarm, digits} !== {1'b0, 24'h000000})
      $display("FAIL zero_digits: got %b/%h want 0/000000", set_alarm, digits);
    else n_pass++;
  endtask

  // glitch is shorter than half a bit so the start-bit recheck rejects it
  task automatic test_glitch;
    int v0, e0;
    v0 = vld_cnt; e0 = err_cnt;
    uart_rxd = 1'b0;
    repeat (20) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (12 * c_bit) @(negedge clk);
    n_checks++;
    if (err_cnt - e0 !== 0) $display("FAIL glitch_err: got %0d want 0", err_cnt - e0); else n_pass++;
    n_checks++;
    if (vld_cnt - v0 !== 0) $display("FAIL glitch_vld: got %0d want 0", vld_cnt - v0); else n_pass++;
    v0 = vld_cnt;
    send_str("A2359\r");
    n_checks++;
    if (vld_cnt - v0 !== 1) $display("FAIL a2359_vld: got %0d want 1", vld_cnt - v0); else n_pass++;
    n_checks++;
    if ({set_alarm, digits} !== {1'b1, 24'h235900})
      $display("FAIL a2359_digits: got %b/%h want 1/235900", set_alarm, digits);
    else n_pass++;
  endtask

  task automatic test_restart_and_illegal;
    int v0, e0;
    v0 = vld_cnt; e0 = err_cnt;
    send_str("x\nT12A0815\r");
    n_checks++;
    if ({vld_cnt - v0, err_cnt - e0} !== {32'd1, 32'd0})
      $display("FAIL restart_pulses: got vld %0d err %0d want 1/0", vld_cnt - v0, err_cnt - e0);
    else n_pass++;
    n_checks++;
    if ({set_alarm, digits} !== {1'b1, 24'h081500})
      $display("FAIL restart_digits: got %b/%h want 1/081500", set_alarm, digits);
    else n_pass++;
    v0 = vld_cnt; e0 = err_cnt;
    send_str("T1x");
    n_checks++;
    if (err_cnt - e0 !== 1) $display("FAIL illegal_err: got %0d want 1", err_cnt - e0); else n_pass++;
    n_checks++;
    if (vld_cnt - v0 !== 0) $display("FAIL illegal_vld: got %0d want 0", vld_cnt - v0); else n_pass++;
  endtask

  task automatic test_reset_midframe;
    int v0, e0;
    logic [7:0] b;
    send_str("T123");
    v0 = vld_cnt; e0 = err_cnt;
    b = 8'h34;
    uart_rxd = 1'b0;
    repeat (c_bit) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = b[i];
      repeat (c_bit) @(negedge clk);
    end
    repeat (c_bit / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({set_vld, set_alarm, cmd_err, digits} !== 27'd0)
      $display("FAIL midrst_outputs: got %b%b%b/%h want 000/000000", set_vld, set_alarm, cmd_err, digits);
    else n_pass++;
    uart_rxd = 1'b1;
    rst_n = 1'b1;
    repeat (12 * c_bit) @(negedge clk);
    n_checks++;
    if ({vld_cnt - v0, err_cnt - e0} !== {32'd0, 32'd0})
      $display("FAIL midrst_pulses: got vld %0d err %0d want 0/0", vld_cnt - v0, err_cnt - e0);
    else n_pass++;
    v0 = vld_cnt; e0 = err_cnt;
    send_str("T235959\r");
    n_checks++;
    if ({vld_cnt - v0, err_cnt - e0} !== {32'd1, 32'd0})
      $display("FAIL t235959_pulses: got vld %0d err %0d want 1/0", vld_cnt - v0, err_cnt - e0);
    else n_pass++;
    n_checks++;
    if ({set_alarm, digits} !== {1'b0, 24'h235959})
      $display("FAIL t235959_digits: got %b/%h want 0/235959", set_alarm, digits);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_time_load;
    test_alarm_load;
    test_range_errors;
    test_framing;
    test_glitch;
    test_restart_and_illegal;
    test_reset_midframe;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
